// File: rtl/conv_pkg.sv
// Shared definitions for the streaming convolution MAC: FSM state encoding,
// a constant log2 helper and width derivations for products and sums.
package conv_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // ceil(log2(v)); 0 for v <= 1
    function automatic int clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return int'(r);
    endfunction

    // Exact signed product width of two DATA_W operands
    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

    // Exact signed width of the sum of 'taps' products
    function automatic int sum_w(input int data_w, input int taps);
        return prod_w(data_w) + clog2(taps);
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered binary adder tree: one level per clock, odd leftover nodes pass
// through. A single stall input freezes every level and its valid bit.
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter  int LEAVES = 16,
    parameter  int W      = 16,
    localparam int LV     = clog2(LEAVES),
    localparam int SW     = W + LV
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [LEAVES*W-1:0]   in_data,
    output logic                  out_valid,
    output logic signed [SW-1:0]  out_sum,
    output logic                  busy
);

    logic [LV:1] lv_vld;

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int CNT = (LEAVES + (1 << l) - 1) >> l;
        logic signed [SW-1:0] node [CNT];
        logic                 vld;

        if (l == 0) begin : g_leaf
            assign vld = in_valid;
            for (genvar i = 0; i < CNT; i++) begin : g_ext
                assign node[i] = SW'($signed(in_data[i*W +: W]));
            end
        end else begin : g_add
            localparam int PCNT = (LEAVES + (1 << (l - 1)) - 1) >> (l - 1);

            assign lv_vld[l] = vld;

            // Level valid bit advances with the pipeline unless stalled
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= 1'b0;
                end else if (!stall) begin
                    vld <= g_lvl[l-1].vld;
                end
            end

            for (genvar i = 0; i < CNT; i++) begin : g_node
                if (2 * i + 1 < PCNT) begin : g_pair
                    // Sum of two child nodes
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            node[i] <= '0;
                        end else if (!stall) begin
                            node[i] <= g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
                        end
                    end
                end else begin : g_pass
                    // Unpaired child is delayed one level unchanged
                    always_ff @(posedge clk or posedge rst) begin
                        if (rst) begin
                            node[i] <= '0;
                        end else if (!stall) begin
                            node[i] <= g_lvl[l-1].node[2*i];
                        end
                    end
                end
            end
        end
    end

    assign out_valid = g_lvl[LV].vld;
    assign out_sum   = g_lvl[LV].node[0];
    assign busy      = |lv_vld;

endmodule

// File: rtl/conv_stream_mac.sv
// KSIZE x KSIZE signed convolution MAC with valid/ready streaming, a serially
// loaded kernel file, registered multiply/adder-tree pipeline with global
// stall, signed saturation to OUT_W and optional ReLU.
// Define CONV_RELU_EN to build the ReLU path; otherwise relu_en is ignored.
module conv_stream_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int KSIZE  = 4,
    parameter int OUT_W  = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          k_valid,
    output logic                          k_ready,
    input  logic [DATA_W-1:0]             k_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [KSIZE*KSIZE*DATA_W-1:0] in_window,
    input  logic                          relu_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_neg,
    output logic                          kernel_ok
);

    localparam int N      = KSIZE * KSIZE;
    localparam int PROD_W = prod_w(DATA_W);
    localparam int SUM_W  = sum_w(DATA_W, N);
    localparam int CNT_W  = clog2(N);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  kern [N];

    logic                      s1_valid;
    logic [N*PROD_W-1:0]       s1_prod;
    logic                      tree_valid;
    logic signed [SUM_W-1:0]   tree_sum;
    logic                      tree_busy;

    logic                      stall;
    logic                      pipe_empty;
    logic                      k_fire;
    logic                      in_fire;
    logic signed [OUT_W-1:0]   sat_val;
    logic                      relu_zero;

    assign stall      = out_valid && !out_ready;
    assign pipe_empty = !s1_valid && !tree_busy && !out_valid;
    // In RUN a pending kernel word takes priority over a window when the
    // pipeline is empty, so in_ready is withheld in exactly that case.
    assign k_ready    = (state != RUN) || pipe_empty;
    assign in_ready   = (state == RUN) && !stall && !(k_valid && pipe_empty);
    assign k_fire     = k_valid && k_ready;
    assign in_fire    = in_valid && in_ready;

    // Kernel load FSM: taps written row-major, RUN once all N are present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            cnt       <= '0;
            kernel_ok <= 1'b0;
            for (int unsigned i = 0; i < N; i++) kern[i] <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (k_fire) begin
                        kern[0] <= k_data;
                        cnt     <= CNT_W'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (k_fire) begin
                        kern[cnt] <= k_data;
                        if (cnt == CNT_W'(N - 1)) begin
                            cnt       <= '0;
                            state     <= RUN;
                            kernel_ok <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (k_fire) begin
                        kern[0]   <= k_data;
                        cnt       <= CNT_W'(1);
                        state     <= LOAD;
                        kernel_ok <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    cnt       <= '0;
                    kernel_ok <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: all N tap products registered on window acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
        end else if (!stall) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                for (int unsigned i = 0; i < N; i++) begin
                    s1_prod[i*PROD_W +: PROD_W] <= PROD_W'(kern[i]) *
                        PROD_W'($signed(in_window[i*DATA_W +: DATA_W]));
                end
            end
        end
    end

    conv_adder_tree #(
        .LEAVES (N),
        .W      (PROD_W)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (s1_valid),
        .in_data   (s1_prod),
        .out_valid (tree_valid),
        .out_sum   (tree_sum),
        .busy      (tree_busy)
    );

    if (SUM_W > OUT_W) begin : g_sat
        localparam logic signed [SUM_W-1:0] SAT_MAX =
            {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
        localparam logic signed [SUM_W-1:0] SAT_MIN =
            {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

        // Clamp the exact sum into the narrower signed output range
        always_comb begin
            if (tree_sum > SAT_MAX) begin
                sat_val = SAT_MAX[OUT_W-1:0];
            end else if (tree_sum < SAT_MIN) begin
                sat_val = SAT_MIN[OUT_W-1:0];
            end else begin
                sat_val = tree_sum[OUT_W-1:0];
            end
        end
    end else begin : g_ext
        assign sat_val = OUT_W'(tree_sum);
    end

`ifdef CONV_RELU_EN
    assign relu_zero = relu_en && tree_sum[SUM_W-1];
`else
    logic unused_relu_en;
    assign unused_relu_en = relu_en;
    assign relu_zero      = 1'b0;
`endif

    // Final stage: sign flag, ReLU and saturation, held while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_neg   <= 1'b0;
        end else if (!stall) begin
            out_valid <= tree_valid;
            if (tree_valid) begin
                out_neg  <= tree_sum[SUM_W-1];
                out_data <= relu_zero ? '0 : sat_val;
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_mac.sv
// Directed self-checking bench for conv_stream_mac (KSIZE=4, OUT_W=16).
module tb_conv_stream_mac;

    localparam int DW = 8;
    localparam int KS = 4;
    localparam int N  = KS * KS;
    localparam int OW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            k_valid;
    logic            k_ready;
    logic [DW-1:0]   k_data;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_window;
    logic            relu_en;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic            out_neg;
    logic            kernel_ok;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] kv [N];

    always #5 clk = ~clk;

    conv_stream_mac #(
        .DATA_W (DW),
        .KSIZE  (KS),
        .OUT_W  (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .k_valid   (k_valid),
        .k_ready   (k_ready),
        .k_data    (k_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_window (in_window),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg),
        .kernel_ok (kernel_ok)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_kernel(input logic [7:0] even_v, input logic [7:0] odd_v);
        for (int i = 0; i < N; i++) kv[i] = (i % 2 == 0) ? even_v : odd_v;
    endtask

    task automatic set_window(input logic [7:0] v);
        for (int i = 0; i < N; i++) in_window[i*DW +: DW] = v;
    endtask

    task automatic load_words(input int first, input int last);
        int guard;
        for (int i = first; i <= last; i++) begin
            k_data  = kv[i];
            k_valid = 1'b1;
            guard   = 0;
            while (!k_ready && guard < 100) begin
                tick();
                guard++;
            end
            n_checks++;
            if (k_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL k_ready_wait: k_ready=%b required 1 for word %0d", k_ready, i);
            end
            tick();
        end
        k_valid = 1'b0;
    endtask

    task automatic send_window(input logic [7:0] v);
        int guard;
        guard = 0;
        set_window(v);
        in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [15:0] exp_d, input logic exp_n);
        int guard;
        guard     = 0;
        out_ready = 1'b1;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_valid: out_valid=%b required 1", name, out_valid);
        end else begin
            n_checks++;
            if (out_data !== exp_d) begin
                n_fail++;
                $display("FAIL %s_data: out_data=%0d required %0d", name,
                         $signed(out_data), $signed(exp_d));
            end
            n_checks++;
            if (out_neg !== exp_n) begin
                n_fail++;
                $display("FAIL %s_neg: out_neg=%b required %b", name, out_neg, exp_n);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (k_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_k_ready: got %b required 1", k_ready); end
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_data !== 16'd0) begin n_fail++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
        n_checks++; if (out_neg !== 1'b0)   begin n_fail++; $display("FAIL rst_out_neg: got %b required 0", out_neg); end
        n_checks++; if (kernel_ok !== 1'b0) begin n_fail++; $display("FAIL rst_kernel_ok: got %b required 0", kernel_ok); end
    endtask

    task automatic test_basic();
        int n;
        set_kernel(8'd1, 8'd1);
        load_words(0, N - 1);
        set_window(8'd3);
        in_valid = 1'b1;
        #1;
        n_checks++; if (kernel_ok !== 1'b1) begin n_fail++; $display("FAIL basic_kernel_ok: got %b required 1", kernel_ok); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL basic_first_in_ready: got %b required 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== 5) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid after %0d edges past handshake, required 5", n);
        end
        expect_out("basic", 16'd48, 1'b0);
    endtask

    task automatic test_saturation();
        set_kernel(8'h80, 8'h80);
        load_words(0, N - 1);
        send_window(8'h80);
        expect_out("sat_pos", 16'h7FFF, 1'b0);
        set_kernel(8'h7F, 8'h7F);
        load_words(0, N - 1);
        send_window(8'h80);
        expect_out("sat_neg", 16'h8000, 1'b1);
    endtask

    task automatic test_relu();
        relu_en = 1'b0;
        set_kernel(8'h01, 8'hFF);
        load_words(0, N - 1);
        send_window(8'd5);
        expect_out("zero_sum", 16'd0, 1'b0);
        set_kernel(8'h00, 8'h00);
        kv[0]   = 8'hFE;
        relu_en = 1'b1;
        load_words(0, N - 1);
        send_window(8'd7);
`ifdef CONV_RELU_EN
        expect_out("relu_neg", 16'd0, 1'b1);
`else
        expect_out("relu_neg", 16'hFFF2, 1'b1);
`endif
        relu_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int sent, recv, k, cyc;
        logic exp_ir;
        logic [15:0] exp_d;
        sent = 0; recv = 0; k = -1; cyc = 0;
        set_kernel(8'd1, 8'd1);
        load_words(0, N - 1);
        while (recv < 20 && cyc < 200) begin
            if (k < 0 && out_valid) k = 0;
            out_ready = !(k >= 3 && k <= 7);
            if (sent < 20) begin
                set_window(8'(sent + 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_ir = !(k >= 3 && k <= 7);
            if (in_valid) begin
                n_checks++;
                if (in_ready !== exp_ir) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: k=%0d in_ready=%b required %b", k, in_ready, exp_ir);
                end
            end
            exp_d = 16'(16 * (recv + 1));
            if (out_valid) begin
                n_checks++;
                if (out_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL b2b_data: result %0d out_data=%0d required %0d", recv, out_data, exp_d);
                end
                if (out_ready) recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            if (k >= 0) k++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv !== 20) begin
            n_fail++;
            $display("FAIL b2b_count: received %0d required 20", recv);
        end
    endtask

    task automatic test_kernel_block();
        int drained, cyc;
        drained = 0; cyc = 0;
        send_window(8'd1);
        send_window(8'd2);
        send_window(8'd3);
        k_data  = 8'd2;
        k_valid = 1'b1;
        while (cyc < 30) begin
            n_checks++;
            if (drained < 3) begin
                if (k_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL kblock_k_ready: drained=%0d k_ready=%b required 0", drained, k_ready);
                end
            end else begin
                if (k_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL kblock_k_ready_after: k_ready=%b required 1", k_ready);
                end
                break;
            end
            if (out_valid) begin
                n_checks++;
                if (out_data !== 16'(16 * (drained + 1))) begin
                    n_fail++;
                    $display("FAIL kblock_data: out_data=%0d required %0d", out_data, 16 * (drained + 1));
                end
                drained++;
            end
            tick();
            cyc++;
        end
        n_checks++;
        if (drained !== 3) begin
            n_fail++;
            $display("FAIL kblock_drain: drained %0d required 3", drained);
        end
        set_kernel(8'd2, 8'd2);
        load_words(0, N - 1);
        send_window(8'd1);
        expect_out("reload", 16'd32, 1'b0);
    endtask

    task automatic test_reset_midload();
        set_kernel(8'd3, 8'd3);
        load_words(0, 8);
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mload_out_valid: got %b required 0", out_valid); end
        n_checks++; if (kernel_ok !== 1'b0) begin n_fail++; $display("FAIL mload_kernel_ok: got %b required 0", kernel_ok); end
        n_checks++; if (k_ready !== 1'b1)   begin n_fail++; $display("FAIL mload_k_ready: got %b required 1", k_ready); end
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mload_in_ready: got %b required 0", in_ready); end
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        load_words(9, 15);
        in_valid = 1'b1;
        #1;
        n_checks++; if (kernel_ok !== 1'b0) begin n_fail++; $display("FAIL mload_partial_ok: got %b required 0", kernel_ok); end
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mload_partial_in_ready: got %b required 0", in_ready); end
        in_valid = 1'b0;
        load_words(0, 8);
        n_checks++; if (kernel_ok !== 1'b1) begin n_fail++; $display("FAIL mload_full_ok: got %b required 1", kernel_ok); end
        send_window(8'd1);
        expect_out("mload_after", 16'd48, 1'b0);
    endtask

    task automatic test_reset_midstream();
        logic seen;
        seen = 1'b0;
        send_window(8'd1);
        send_window(8'd2);
        send_window(8'd3);
        send_window(8'd4);
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mstream_out_valid: got %b required 0", out_valid); end
        n_checks++; if (kernel_ok !== 1'b0) begin n_fail++; $display("FAIL mstream_kernel_ok: got %b required 0", kernel_ok); end
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        set_window(8'd1);
        in_valid  = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mstream_in_ready: got %b required 0", in_ready); end
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mstream_discard: stale out_valid=%b required 0", seen); end
        set_kernel(8'd1, 8'd1);
        load_words(0, N - 1);
        send_window(8'd2);
        expect_out("mstream_after", 16'd32, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        k_valid   = 1'b0;
        k_data    = '0;
        in_valid  = 1'b0;
        in_window = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;

        test_reset();
        test_basic();
        test_saturation();
        test_relu();
        test_back_to_back();
        test_kernel_block();
        test_reset_midload();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_stream_mac.md
# conv_stream_mac

Parametrised, pipelined KSIZE×KSIZE signed convolution MAC with valid/ready streaming. It succeeds the fixed 4×4 window unit. It adds a serially loaded kernel register file, a registered multiply/adder-tree pipeline with full back-pressure, runtime ReLU with a negative flag, and signed saturation to the output width. It sits between the window-generator (line buffer) and the feature-map writer.

## Interface
- `DATA_W`, 8, signed width of each pixel and kernel element.
- `KSIZE`, 4, kernel/window edge length (≥2); `N = KSIZE*KSIZE` taps.
- `OUT_W`, 25, signed output width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `k_valid`  in  1  kernel word valid.
- `k_ready`  out  1  kernel word accepted when `k_valid && k_ready`.
- `k_data`  in  DATA_W  kernel element, row-major order, tap 0 first.
- `in_valid`  in  1  window valid.
- `in_ready`  out  1  window accepted when `in_valid && in_ready`.
- `in_window`  in  N*DATA_W  tap (r,c) at bits `[(r*KSIZE+c)*DATA_W +: DATA_W]`.
- `relu_en`  in  1  quasi-static; change only while pipeline empty.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  OUT_W  result.
- `out_neg`  out  1  pre-ReLU sum was negative.
- `kernel_ok`  out  1  full kernel loaded (state RUN).

## Operation
- Widths: `PROD_W = 2*DATA_W`; `SUM_W = PROD_W + clog2(N)`. All products and sums are exact signed with no intermediate overflow.
- FSM, encoded in the package:
  - EMPTY (reset state): `k_ready=1`, `in_ready=0`. An accepted kernel word writes tap 0, sets cnt=1, and moves to LOAD.
  - LOAD: `k_ready=1`, `in_ready=0`. Each accepted word writes tap[cnt] and increments cnt. The word with cnt==N-1 moves to RUN and clears cnt.
  - RUN: `in_ready = !(out_valid && !out_ready)`. `k_ready=1` only when every pipeline stage is invalid. An accepted kernel word there writes tap 0 and moves to LOAD. The kernel is otherwise never modified while windows are in flight.
- Simultaneous `k_valid` and `in_valid` in RUN with an empty pipeline: the kernel word wins. `in_ready` is 0 that cycle.
- Pipeline stages, each registered with a valid bit:
  - S1: N products.
  - S2..S(1+clog2 N): binary adder tree, one level per stage. An odd leftover passes through.
  - Final stage: post-process.
- Post-process of sum `s`:
  - `out_neg = (s<0)`.
  - If `relu_en` and `s<0`, the result is 0.
  - If `SUM_W > OUT_W`, clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
  - Otherwise sign-extend.
- Back-pressure is a global stall: while `out_valid && !out_ready`, every stage holds and `in_ready=0`. There are no bubbles and no drops, and throughput is one window per cycle.
- Reset (including mid-load or mid-stream) has immediate effect:
  - All valid bits clear, and kernel taps clear to 0.
  - cnt clears to 0, and the state returns to EMPTY.
  - In-flight results are discarded.

## Timing
- Reset values: `k_ready=1`, `in_ready=0`, `out_valid=0`, `out_data=0`, `out_neg=0`, `kernel_ok=0`.
- Latency L = 2 + clog2(N) cycles from the window handshake to `out_valid`, with no stalls. Default L=6.
- `kernel_ok` rises the cycle after the Nth kernel handshake. The earliest window handshake is that same cycle.
- `out_data` and `out_neg` are stable while `out_valid && !out_ready`.
- All outputs are registered. No combinational path runs from `out_ready` to `out_valid`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `CONV_RELU_EN` defined: `relu_en` is honoured as described.
- `CONV_RELU_EN` undefined: the ReLU logic is not built and `relu_en` is ignored. Results are always signed, with saturation only. `out_neg` still reports the sign.

## Structure
- Package `conv_pkg` holds:
  - FSM state enumeration (EMPTY, LOAD, RUN).
  - The `clog2` constant function.
  - Derived width constants `PROD_W` and `SUM_W`, computed from the parameters.
- Sub-module `conv_adder_tree`, parametrised by leaf count and width, owns the registered tree levels and their valid/stall chain. The top level holds the FSM, kernel file, multipliers and post-process.

## Test plan
- Load kernel all +1 (N=16), window all +3 → one output after 6 cycles: `out_data=48`, `out_neg=0`.
- Kernel all −128, window all −128, `OUT_W=16`, `relu_en=0` → sum 262144 saturates to `out_data=32767`. Kernel all +127 with window all −128 → −32768.
- Kernel alternating ±1, window all 5, sum −0 → `out_data=0`, `out_neg=0`. Kernel tap 0 = −2, rest 0, window all 7, `relu_en=1` → `out_data=0`, `out_neg=1`. With the macro undefined, the same case gives `out_data=−14`.
- Stream 20 back-to-back windows, with `out_ready` low for cycles 3–7 after the first result → all 20 results arrive in order and none are lost. `in_ready` is low exactly while stalled.
- Kernel word offered in RUN while the pipeline holds 3 windows → `k_ready=0` until the last result drains. Then reload to all +2, and window all 1 gives 32.
- Assert `rst` after 9 of 16 kernel words, or with 4 windows in flight → next cycle `out_valid=0`, `kernel_ok=0`, state EMPTY. A full reload is required before `in_ready` rises.
